sfu_op_sequencer: RTL and testbench
===================================

// Module: sfu_op_sequencer
// PURPOSE
//  Parametrised special-function sequencer. Accepts one DIM-wide fp16 vector per op.
//  Executes LayerNorm-affine, RoPE or residual-add as a step sequence on the shared VPE,
//  using a valid/ready request and a valid response. Sits between the activation buffer
//  and the HBM-fed constants. Holds all intermediates; in_data only sampled on accept.
// PARAMETERS
//  DIM      128   vector length (even, >=2)
//  DW       16    element width; MSB is sign
//  TIMEOUT  255   max cycles waiting for vpe_rsp_valid before abort (>=1)
// PORTS
//  clk            in   1         clock
//  rst_n          in   1         synchronous active-low reset
//  in_valid       in   1         op request
//  in_ready       out  1         sequencer idle, can accept
//  in_op          in   2         00 LN, 01 ROPE, 10 ADD, 11 RELU/illegal
//  in_data        in   DIMxDW    operand vector x
//  in_aux         in   DIMxDW    residual vector (ADD)
//  in_nmean       in   DW        -mean (LN)
//  in_rstd        in   DW        1/std (LN)
//  gmma, beta     in   DW        LN affine scalars
//  sines, cosines in   DIM/2xDW  RoPE tables, one per pair
//  out_valid      out  1         result held
//  out_ready      in   1         consumer takes result
//  out_data       out  DIMxDW    result vector
//  out_err        out  1         qualified by out_valid; timeout or illegal op
//  vpe_req_valid  out  1         VPE request
//  vpe_req_ready  in   1         VPE accepts request
//  vpe_mode       out  2         00 vec*sca, 01 vec*vec, 10 vec+vec, 11 vec+sca
//  vpe_vec1/2     out  DIMxDW    VPE vector operands
//  vpe_sca        out  DW        VPE scalar operand
//  vpe_rsp_valid  in   1         one-cycle response strobe
//  vpe_rsp_vec    in   DIMxDW    VPE result
//  busy           out  1         state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   state=IDLE. in_ready=1. out_valid, out_err, vpe_req_valid, busy=0.
//   vpe_mode=0. All data regs and vectors = 0.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//   IDLE: in_valid&in_ready latches all inputs and sets step=0.
//     Illegal op goes straight to DONE with err=1 and out_data=x.
//   ISSUE: vpe_req_valid=1 and operands held stable until vpe_req_ready; then WAIT.
//   WAIT: on vpe_rsp_valid, store acc<=rsp (step 0 of ROPE stores tmp).
//     Last step -> DONE, else step++ and ISSUE.
//     Watchdog counts WAIT cycles; at TIMEOUT -> DONE with err=1 and out_data=acc.
//   DONE: out_valid=1 with data stable until out_ready; then IDLE.
//     in_ready=1 only in IDLE, so there is no overlap.
//  Steps:
//   LN:   acc=x+nmean(11), acc*rstd(00), acc*gmma(00), acc+beta(11). 4 requests.
//   ROPE: tmp=x*cos_r(01), acc=x_r*sin_r(01), acc=tmp+acc(10). 3 requests.
//         Pair k: cos_r[2k]=cos_r[2k+1]=cosines[k], same for sin_r.
//         x_r[2k]=x[2k+1] with MSB inverted, x_r[2k+1]=x[2k].
//   ADD:  acc=x+aux(10). 1 request.
//  vpe_rsp_valid outside WAIT is ignored.
//  Minimum latency, accept to out_valid: 2*steps+1 cycles (ready/rsp same cycle).
//  Synchronous reset mid-op aborts; any late vpe_rsp_valid is ignored.
// CONFIGURATION
//  SFU_RELU_EN defined:
//   op 11 = ReLU, computed locally with no VPE request.
//   Element = 0 if MSB=1, else passthrough. Result in DONE 1 cycle after accept. err=0.
//  SFU_RELU_EN undefined: op 11 is illegal; out_err=1, out_data=x.
// STRUCTURE
//  Package sfu_pkg: sfu_op_e, vpe_mode_e, state_e, step-count localparams.
//  Sub-module sfu_rope_reorder: combinational pair swap/sign and table duplication.
// TESTING
//  ADD x=all 0x3C00, aux=all 0x4000, VPE model 1-cycle -> out_data=all 0x4200, err=0.
//  LN: check request order and operands (modes 11,00,00,11; sca=nmean,rstd,gmma,beta).
//   out_ready=0 for 5 cycles -> out_valid held and data stable.
//  ROPE x[0]=0x3C00, x[1]=0x4000 -> 2nd request vec1[0]=0xC000, vec1[1]=0x3C00.
//  VPE withholds vpe_req_ready 3 cycles -> operands stable; then no rsp for TIMEOUT -> err=1.
//  op 11, x[0]=0xBC00, x[1]=0x3C00: with SFU_RELU_EN -> {0x0000,0x3C00}, no vpe_req.
//   Without it -> err=1.
//  rst_n=0 during WAIT of LN -> next cycle IDLE/in_ready=1; stray rsp ignored; new ADD correct.

Source files
------------

// File: rtl/sfu_pkg.sv
// sfu_pkg: shared opcode, VPE mode and FSM state types for the SFU sequencer.
// Step-count helpers give the index of the final VPE request per op.
package sfu_pkg;

    typedef enum logic [1:0] {
        OP_LN   = 2'b00,
        OP_ROPE = 2'b01,
        OP_ADD  = 2'b10,
        OP_RELU = 2'b11
    } sfu_op_e;

    typedef enum logic [1:0] {
        VM_VS    = 2'b00,
        VM_VV    = 2'b01,
        VM_VADD  = 2'b10,
        VM_VSADD = 2'b11
    } vpe_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam logic [1:0] LN_LAST   = 2'd3;
    localparam logic [1:0] ROPE_LAST = 2'd2;
    localparam logic [1:0] ADD_LAST  = 2'd0;

    function automatic logic [1:0] last_step(sfu_op_e op);
        case (op)
            OP_LN:   return LN_LAST;
            OP_ROPE: return ROPE_LAST;
            default: return ADD_LAST;
        endcase
    endfunction

endpackage

// File: rtl/sfu_rope_reorder.sv
// sfu_rope_reorder: RoPE pair rotation of x (swap, negate even lane)
// and duplication of the per-pair sine/cosine tables to full width.
module sfu_rope_reorder #(
    parameter int DIM = 128,
    parameter int DW  = 16
) (
    input  logic [DIM*DW-1:0]   x,
    input  logic [DIM/2*DW-1:0] sines,
    input  logic [DIM/2*DW-1:0] cosines,
    output logic [DIM*DW-1:0]   x_r,
    output logic [DIM*DW-1:0]   sin_r,
    output logic [DIM*DW-1:0]   cos_r
);

    for (genvar k = 0; k < DIM / 2; k++) begin : g_pair
        assign x_r[2*k*DW +: DW]     = {~x[(2*k+2)*DW-1], x[(2*k+1)*DW +: DW-1]};
        assign x_r[(2*k+1)*DW +: DW] = x[2*k*DW +: DW];
        assign sin_r[2*k*DW +: DW]     = sines[k*DW +: DW];
        assign sin_r[(2*k+1)*DW +: DW] = sines[k*DW +: DW];
        assign cos_r[2*k*DW +: DW]     = cosines[k*DW +: DW];
        assign cos_r[(2*k+1)*DW +: DW] = cosines[k*DW +: DW];
    end

endmodule

// File: rtl/sfu_op_sequencer.sv
// sfu_op_sequencer: runs LN-affine, RoPE or residual-add as VPE request steps.
// Define SFU_RELU_EN to execute op 11 as a local ReLU instead of an error.
module sfu_op_sequencer
    import sfu_pkg::*;
#(
    parameter int DIM     = 128,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [DIM*DW-1:0]   in_data,
    input  logic [DIM*DW-1:0]   in_aux,
    input  logic [DW-1:0]       in_nmean,
    input  logic [DW-1:0]       in_rstd,
    input  logic [DW-1:0]       gmma,
    input  logic [DW-1:0]       beta,
    input  logic [DIM/2*DW-1:0] sines,
    input  logic [DIM/2*DW-1:0] cosines,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIM*DW-1:0]   out_data,
    output logic                out_err,
    output logic                vpe_req_valid,
    input  logic                vpe_req_ready,
    output logic [1:0]          vpe_mode,
    output logic [DIM*DW-1:0]   vpe_vec1,
    output logic [DIM*DW-1:0]   vpe_vec2,
    output logic [DW-1:0]       vpe_sca,
    input  logic                vpe_rsp_valid,
    input  logic [DIM*DW-1:0]   vpe_rsp_vec,
    output logic                busy
);

    localparam int VW = DIM * DW;
    localparam int HW = DIM / 2 * DW;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state;
    sfu_op_e       op_q;
    logic [1:0]    step;
    logic [VW-1:0] x_q, acc, tmp;
    logic [HW-1:0] sin_q;
    logic [DW-1:0] rstd_q, gmma_q, beta_q;
    logic [CW-1:0] wdog;

    logic [VW-1:0] x_r, sin_r, cos_r;

    sfu_rope_reorder #(.DIM(DIM), .DW(DW)) u_rope (
        .x       (x_q),
        .sines   (sin_q),
        .cosines (cosines),
        .x_r     (x_r),
        .sin_r   (sin_r),
        .cos_r   (cos_r)
    );

    // Operands of the next request: step 0 comes straight from the inputs
    // on accept, later steps from latched state and the arriving response.
    sfu_op_e       nop;
    logic [1:0]    nstep;
    vpe_mode_e     nmode;
    logic [VW-1:0] nv1, nv2;
    logic [DW-1:0] nsca;

    assign nop   = (state == S_IDLE) ? sfu_op_e'(in_op) : op_q;
    assign nstep = (state == S_IDLE) ? 2'd0 : step + 2'd1;

    always_comb begin
        nmode = VM_VS;
        nv1   = vpe_rsp_vec;
        nv2   = '0;
        nsca  = '0;
        case (nop)
            OP_LN: begin
                nmode = (nstep == 2'd0 || nstep == 2'd3) ? VM_VSADD : VM_VS;
                case (nstep)
                    2'd0: begin
                        nv1  = in_data;
                        nsca = in_nmean;
                    end
                    2'd1:    nsca = rstd_q;
                    2'd2:    nsca = gmma_q;
                    default: nsca = beta_q;
                endcase
            end
            OP_ROPE: begin
                case (nstep)
                    2'd0: begin
                        nmode = VM_VV;
                        nv1   = in_data;
                        nv2   = cos_r;
                    end
                    2'd1: begin
                        nmode = VM_VV;
                        nv1   = x_r;
                        nv2   = sin_r;
                    end
                    default: begin
                        nmode = VM_VADD;
                        nv1   = tmp;
                        nv2   = vpe_rsp_vec;
                    end
                endcase
            end
            default: begin
                nmode = VM_VADD;
                nv1   = in_data;
                nv2   = in_aux;
            end
        endcase
    end

`ifdef SFU_RELU_EN
    logic [VW-1:0] relu_x;
    always_comb begin
        relu_x = in_data;
        for (int i = 0; i < DIM; i++)
            if (in_data[i*DW+DW-1]) relu_x[i*DW +: DW] = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            op_q          <= OP_LN;
            step          <= '0;
            x_q           <= '0;
            acc           <= '0;
            tmp           <= '0;
            sin_q         <= '0;
            rstd_q        <= '0;
            gmma_q        <= '0;
            beta_q        <= '0;
            wdog          <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_err       <= 1'b0;
            out_data      <= '0;
            vpe_req_valid <= 1'b0;
            vpe_mode      <= '0;
            vpe_vec1      <= '0;
            vpe_vec2      <= '0;
            vpe_sca       <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q     <= sfu_op_e'(in_op);
                    x_q      <= in_data;
                    sin_q    <= sines;
                    rstd_q   <= in_rstd;
                    gmma_q   <= gmma;
                    beta_q   <= beta;
                    step     <= '0;
                    wdog     <= '0;
                    acc      <= '0;
                    tmp      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    if (in_op == OP_RELU) begin
`ifdef SFU_RELU_EN
                        out_data <= relu_x;
                        out_err  <= 1'b0;
`else
                        out_data <= in_data;
                        out_err  <= 1'b1;
`endif
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        vpe_req_valid <= 1'b1;
                        vpe_mode      <= nmode;
                        vpe_vec1      <= nv1;
                        vpe_vec2      <= nv2;
                        vpe_sca       <= nsca;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: if (vpe_req_ready) begin
                    vpe_req_valid <= 1'b0;
                    wdog          <= '0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    if (vpe_rsp_valid) begin
                        if (op_q == OP_ROPE && step == 2'd0) tmp <= vpe_rsp_vec;
                        else acc <= vpe_rsp_vec;
                        if (step == last_step(op_q)) begin
                            out_data  <= vpe_rsp_vec;
                            out_err   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            step          <= nstep;
                            vpe_req_valid <= 1'b1;
                            vpe_mode      <= nmode;
                            vpe_vec1      <= nv1;
                            vpe_vec2      <= nv2;
                            vpe_sca       <= nsca;
                            state         <= S_ISSUE;
                        end
                    end else if (wdog == CW'(TIMEOUT - 1)) begin
                        out_data  <= acc;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wdog <= wdog + CW'(1);
                    end
                end
                default: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_err   <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfu_op_sequencer.sv
// tb_sfu_op_sequencer: table vectors, directed corner sequences and random ops
// checked against a real-arithmetic fp16 reference with a VPE behavioural model.
module tb_sfu_op_sequencer;

    localparam int DIM     = 8;
    localparam int DW      = 16;
    localparam int TIMEOUT = 20;
    localparam int VW      = DIM * DW;
    localparam int HW      = DIM / 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [1:0]    in_op;
    logic [VW-1:0] in_data, in_aux;
    logic [15:0]   in_nmean, in_rstd, gmma, beta;
    logic [HW-1:0] sines, cosines;
    logic          out_valid, out_ready, out_err;
    logic [VW-1:0] out_data;
    logic          vpe_req_valid, vpe_req_ready;
    logic [1:0]    vpe_mode;
    logic [VW-1:0] vpe_vec1, vpe_vec2, vpe_rsp_vec;
    logic [15:0]   vpe_sca;
    logic          vpe_rsp_valid, busy;

    sfu_op_sequencer #(.DIM(DIM), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_aux(in_aux),
        .in_nmean(in_nmean), .in_rstd(in_rstd), .gmma(gmma), .beta(beta),
        .sines(sines), .cosines(cosines),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .vpe_req_valid(vpe_req_valid), .vpe_req_ready(vpe_req_ready),
        .vpe_mode(vpe_mode), .vpe_vec1(vpe_vec1), .vpe_vec2(vpe_vec2),
        .vpe_sca(vpe_sca), .vpe_rsp_valid(vpe_rsp_valid),
        .vpe_rsp_vec(vpe_rsp_vec), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- fp16 helpers (real arithmetic) ----------------
    function automatic real pw2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) v = real'(h[9:0]) * pw2(-24);
        else v = real'({1'b1, h[9:0]}) * pw2(e - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  a;
        int   ex, m;
        s  = (r < 0.0);
        a  = s ? -r : r;
        ex = 0;
        if (a == 0.0) return {s, 15'd0};
        if (a >= 65504.0) return {s, 15'h7BFF};
        while (a >= 2.0) begin a = a / 2.0; ex++; end
        while (a < 1.0) begin a = a * 2.0; ex--; end
        if (ex < -14) begin
            m = int'(a * pw2(ex + 24));
            return {s, 15'(m)};
        end
        m = int'((a - 1.0) * 1024.0);
        if (m == 1024) begin m = 0; ex++; end
        if (ex > 15) return {s, 15'h7BFF};
        return {s, 5'(ex + 15), 10'(m)};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] a, b);
        return r2h(h2r(a) * h2r(b));
    endfunction

    function automatic logic [15:0] rnd_h();
        return {1'($urandom), 5'($urandom_range(17, 12)), 10'($urandom)};
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < DIM; i++) v[i*16 +: 16] = rnd_h();
        return v;
    endfunction

    function automatic logic [HW-1:0] rnd_half();
        logic [HW-1:0] v;
        for (int i = 0; i < DIM / 2; i++) v[i*16 +: 16] = rnd_h();
        return v;
    endfunction

    // ---------------- reference model: whole-op formulas ----------------
    function automatic void ref_op(
        input  logic [1:0] op, input logic [VW-1:0] x, aux,
        input  logic [15:0] nm, rs, gm, be, input logic [HW-1:0] sn, cs,
        output logic [VW-1:0] y, output logic e);
        logic [15:0] xi, xr, s, c;
        e = 1'b0;
        y = '0;
        for (int i = 0; i < DIM; i++) begin
            xi = x[i*16 +: 16];
            s  = sn[(i/2)*16 +: 16];
            c  = cs[(i/2)*16 +: 16];
            if (i % 2 == 0) begin
                xr = x[(i+1)*16 +: 16];
                xr[15] = ~xr[15];
            end else begin
                xr = x[(i-1)*16 +: 16];
            end
            case (op)
                2'd0: y[i*16 +: 16] = fadd(fmul(fmul(fadd(xi, nm), rs), gm), be);
                2'd1: y[i*16 +: 16] = fadd(fmul(xi, c), fmul(xr, s));
                2'd2: y[i*16 +: 16] = fadd(xi, aux[i*16 +: 16]);
                default: begin
`ifdef SFU_RELU_EN
                    y[i*16 +: 16] = xi[15] ? 16'h0000 : xi;
`else
                    y[i*16 +: 16] = xi;
                    e = 1'b1;
`endif
                end
            endcase
        end
    endfunction

    // ---------------- VPE behavioural model ----------------
    int rdy_pct = 100;
    int lat_max = 1;
    int hold    = 0;
    bit mute    = 1'b0;
    bit stray   = 1'b0;

    logic [1:0]    lg_mode [64];
    logic [15:0]   lg_sca  [64];
    logic [VW-1:0] lg_v1   [64];
    int            log_n = 0;

    function automatic logic [VW-1:0] vpe_calc(
        input logic [1:0] m, input logic [VW-1:0] v1, v2, input logic [15:0] s);
        logic [VW-1:0] r;
        logic [15:0]   b;
        for (int i = 0; i < DIM; i++) begin
            b = (m == 2'b00 || m == 2'b11) ? s : v2[i*16 +: 16];
            r[i*16 +: 16] = m[1] ? fadd(v1[i*16 +: 16], b) : fmul(v1[i*16 +: 16], b);
        end
        return r;
    endfunction

    initial begin
        int            pend, seen;
        logic [VW-1:0] pres;
        pend = 0;
        seen = 0;
        pres = '0;
        vpe_req_ready = 1'b0;
        vpe_rsp_valid = 1'b0;
        vpe_rsp_vec   = '0;
        forever begin
            @(negedge clk);
            vpe_rsp_valid = 1'b0;
            vpe_req_ready = 1'b0;
            if (!rst_n) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !mute) begin
                    vpe_rsp_valid = 1'b1;
                    vpe_rsp_vec   = pres;
                end
            end
            if (stray) begin
                vpe_rsp_valid = 1'b1;
                vpe_rsp_vec   = rnd_vec();
            end
            if (vpe_req_valid && rst_n) seen++;
            else seen = 0;
            if (seen > hold && $urandom_range(99) < rdy_pct) begin
                vpe_req_ready = 1'b1;
                lg_mode[log_n % 64] = vpe_mode;
                lg_sca[log_n % 64]  = vpe_sca;
                lg_v1[log_n % 64]   = vpe_vec1;
                log_n++;
                pres = vpe_calc(vpe_mode, vpe_vec1, vpe_vec2, vpe_sca);
                pend = $urandom_range(lat_max, 1);
            end
        end
    end

    // ---------------- stimulus records and tasks ----------------
    typedef struct {
        logic [1:0]    op;
        logic [VW-1:0] x, aux;
        logic [15:0]   nm, rs, gm, be;
        logic [HW-1:0] sn, cs;
        logic [VW-1:0] exp_d;
        logic          exp_e;
        int            lat;
        string         name;
    } vec_t;

    function automatic int op_lat(input logic [1:0] op);
        case (op)
            2'd0: return 9;
            2'd1: return 7;
            2'd2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input string nm);
        vec_t v;
        v.op = op;
        v.x = rnd_vec(); v.aux = rnd_vec();
        v.nm = rnd_h(); v.rs = rnd_h(); v.gm = rnd_h(); v.be = rnd_h();
        v.sn = rnd_half(); v.cs = rnd_half();
        ref_op(v.op, v.x, v.aux, v.nm, v.rs, v.gm, v.be, v.sn, v.cs, v.exp_d, v.exp_e);
        v.lat  = op_lat(op);
        v.name = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic scramble();
        in_op = 2'($urandom);
        in_data = rnd_vec(); in_aux = rnd_vec();
        in_nmean = rnd_h(); in_rstd = rnd_h(); gmma = rnd_h(); beta = rnd_h();
        sines = rnd_half(); cosines = rnd_half();
    endtask

    task automatic start_op(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_%s in_ready never rose", v.name);
        end
        in_valid = 1'b1; in_op = v.op;
        in_data = v.x; in_aux = v.aux;
        in_nmean = v.nm; in_rstd = v.rs; gmma = v.gm; beta = v.be;
        sines = v.sn; cosines = v.cs;
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_out(input string nm, input int c0, output int c);
        c = c0;
        while (!out_valid && c < 150) begin @(negedge clk); c++; end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout out_valid=0 after %0d cycles", nm, c);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t tbl[5];
    vec_t v;
    int   c, base;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        scramble();
        in_op = 2'd0;

        tbl[0] = mk(2'd2, "add_const");
        tbl[0].x = {DIM{16'h3C00}};
        tbl[0].aux = {DIM{16'h4000}};
        tbl[0].exp_d = {DIM{16'h4200}};
        tbl[0].exp_e = 1'b0;
        tbl[1] = mk(2'd1, "rope");
        tbl[1].x[31:0] = 32'h4000_3C00;
        ref_op(2'd1, tbl[1].x, tbl[1].aux, tbl[1].nm, tbl[1].rs, tbl[1].gm,
               tbl[1].be, tbl[1].sn, tbl[1].cs, tbl[1].exp_d, tbl[1].exp_e);
        tbl[2] = mk(2'd0, "ln");
        tbl[3] = mk(2'd3, "relu");
        tbl[3].x = {(DIM/2){16'h3C00, 16'hBC00}};
`ifdef SFU_RELU_EN
        tbl[3].exp_d = {(DIM/2){16'h3C00, 16'h0000}};
        tbl[3].exp_e = 1'b0;
`else
        tbl[3].exp_d = {(DIM/2){16'h3C00, 16'hBC00}};
        tbl[3].exp_e = 1'b1;
`endif
        tbl[4] = mk(2'd2, "add_rand");

        repeat (3) @(negedge clk);
        chk("rst_ctl", VW'({in_ready, busy, out_valid, out_err, vpe_req_valid, vpe_mode}),
            VW'(7'b1000000));
        chk("rst_out", out_data, '0);
        chk("rst_vec", vpe_vec1 | vpe_vec2 | VW'(vpe_sca), '0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            base = log_n;
            start_op(tbl[i]);
            wait_out(tbl[i].name, 1, c);
            chk({tbl[i].name, "_data"}, out_data, tbl[i].exp_d);
            chk({tbl[i].name, "_err"}, VW'(out_err), VW'(tbl[i].exp_e));
            chk({tbl[i].name, "_lat"}, VW'(c), VW'(tbl[i].lat));
            if (tbl[i].op == 2'd1)
                chk("rope_xr", VW'(lg_v1[(base + 1) % 64][31:0]), VW'(32'h3C00_C000));
            if (tbl[i].op == 2'd3)
                chk("relu_noreq", VW'(log_n), VW'(base));
            take();
        end

        // LN request order, then output held while out_ready stays low
        v = mk(2'd0, "ln_seq");
        base = log_n;
        start_op(v);
        wait_out("ln_seq", 1, c);
        chk("ln_req0", VW'({lg_mode[base % 64], lg_sca[base % 64]}), VW'({2'b11, v.nm}));
        chk("ln_req0_v1", lg_v1[base % 64], v.x);
        chk("ln_req1", VW'({lg_mode[(base+1) % 64], lg_sca[(base+1) % 64]}), VW'({2'b00, v.rs}));
        chk("ln_req2", VW'({lg_mode[(base+2) % 64], lg_sca[(base+2) % 64]}), VW'({2'b00, v.gm}));
        chk("ln_req3", VW'({lg_mode[(base+3) % 64], lg_sca[(base+3) % 64]}), VW'({2'b11, v.be}));
        chk("ln_nreq", VW'(log_n - base), VW'(4));
        for (int k = 0; k < 5; k++) begin
            chk("ln_hold_valid", VW'(out_valid), VW'(1));
            chk("ln_hold_data", out_data, v.exp_d);
            @(negedge clk);
        end
        take();

        // ready withheld 3 cycles, then no response: watchdog abort
        v = mk(2'd2, "tmo");
        hold = 3;
        mute = 1'b1;
        start_op(v);
        for (int k = 0; k < 3; k++) begin
            chk("hold_ctl", VW'({vpe_req_valid, vpe_mode}), VW'(3'b110));
            chk("hold_v1", vpe_vec1, v.x);
            chk("hold_v2", vpe_vec2, v.aux);
            @(negedge clk);
        end
        wait_out("tmo", 4, c);
        chk("tmo_lat", VW'(c), VW'(5 + TIMEOUT));
        chk("tmo_err", VW'(out_err), VW'(1));
        chk("tmo_data", out_data, '0);
        hold = 0;
        mute = 1'b0;
        take();

        // reset during LN WAIT, stray responses, then a clean ADD
        v = mk(2'd0, "ln_rst");
        mute = 1'b1;
        start_op(v);
        repeat (2) @(negedge clk);
        chk("wait_busy", VW'({busy, vpe_req_valid}), VW'(2'b10));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ctl", VW'({in_ready, busy, out_valid, vpe_req_valid}), VW'(4'b1000));
        rst_n = 1'b1;
        mute = 1'b0;
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        chk("stray_ign", VW'({in_ready, busy, out_valid}), VW'(3'b100));
        v = mk(2'd2, "post_rst");
        start_op(v);
        wait_out("post_rst", 1, c);
        chk("post_rst_data", out_data, v.exp_d);
        chk("post_rst_err", VW'(out_err), VW'(0));
        take();

        // randomized ops with random VPE handshakes and consumer stalls
        rdy_pct = 60;
        lat_max = 4;
        for (int i = 0; i < 40; i++) begin
            v = mk(2'($urandom), "rand");
            start_op(v);
            wait_out("rand", 1, c);
            chk("rand_data", out_data, v.exp_d);
            chk("rand_err", VW'(out_err), VW'(v.exp_e));
            repeat ($urandom_range(2)) @(negedge clk);
            take();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
